// File: rtl/bcd_counter_n_pkg.sv
// Shared BCD constants and digit-validity helper for the multi-digit BCD counter.
package bcd_counter_n_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic logic bcd_valid(input logic [3:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_counter_n_bcd_digit.sv
// One BCD decade: clear/load/count next-state logic and its 4-bit register.
module bcd_digit
    import bcd_counter_n_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ci,
    input  logic       i_up,
    input  logic       i_clr,
    input  logic       i_load,
    input  logic [3:0] i_d,
    output logic [3:0] o_q,
    output logic       o_term
);

    logic [3:0] r_q;
    logic [3:0] w_next;

    always_comb begin
        w_next = r_q;
        if (i_clr) begin
            w_next = BCD_MIN;
        end else if (i_load) begin
            w_next = bcd_valid(i_d) ? i_d : BCD_MIN;
        end else if (i_ci) begin
            if (i_up) begin
                w_next = (r_q >= BCD_MAX) ? BCD_MIN : r_q + 4'd1;
            end else begin
                w_next = (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= BCD_MIN;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_q    = r_q;
    // Terminal flag doubles as the carry/borrow enable for the next decade.
    assign o_term = i_up ? (r_q == BCD_MAX) : (r_q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// Parametrised multi-digit BCD up/down counter with load, clear, saturate/wrap,
// cascade terminal count and sticky load-error flag.
module bcd_counter_n
    import bcd_counter_n_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SATURATE = 0
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic                  EN,
    input  logic                  CLR,
    input  logic                  LOAD,
    input  logic                  UP_DN,
    input  logic [4*DIGITS-1:0]   D,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  TC,
    output logic                  WRAP,
    output logic                  ERR
);

    logic [DIGITS-1:0] w_term;
    logic [DIGITS-1:0] w_ci;
    logic              w_all_term;
    logic              w_cnt_en;
    logic              w_wrap_evt;
    logic              w_ld_bad;
    logic              r_wrap;
    logic              r_err;

    assign w_all_term = &w_term;
    // In saturate mode the whole chain is frozen once the terminal value is reached.
    assign w_cnt_en   = EN & ~((SATURATE != 0) & w_all_term);
    assign w_wrap_evt = (SATURATE == 0) & EN & w_all_term;

    always_comb begin
        w_ld_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(D[4*i +: 4])) begin
                w_ld_bad = 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            if (g == 0) begin : g_first
                assign w_ci[g] = w_cnt_en;
            end else begin : g_rest
                assign w_ci[g] = w_ci[g-1] & w_term[g-1];
            end

            bcd_digit u_digit (
                .i_clk   (CLK),
                .i_rst_n (RES),
                .i_ci    (w_ci[g]),
                .i_up    (UP_DN),
                .i_clr   (CLR),
                .i_load  (LOAD),
                .i_d     (D[4*g +: 4]),
                .o_q     (Q[4*g +: 4]),
                .o_term  (w_term[g])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else if (CLR) begin
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else if (LOAD) begin
            r_wrap <= 1'b0;
            if (w_ld_bad) begin
                r_err <= 1'b1;
            end
        end else begin
            r_wrap <= w_wrap_evt;
        end
    end

    assign TC   = EN & w_all_term;
    assign WRAP = r_wrap;
    assign ERR  = r_err;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed self-checking bench for bcd_counter_n (2-digit wrap, 3-digit wrap, 2-digit saturate).
module tb_bcd_counter_n;

    logic        CLK;
    logic        RES;
    logic        EN;
    logic        CLR;
    logic        LOAD;
    logic        UP_DN;
    logic [7:0]  d2, ds, q2, qs;
    logic [11:0] d3, q3;
    logic        tc2, wrap2, err2;
    logic        tc3, wrap3, err3;
    logic        tcs, wraps, errs;

    int errors = 0;
    int checks = 0;

    bcd_counter_n #(.DIGITS(2), .SATURATE(0)) u_dut2 (
        .CLK(CLK), .RES(RES), .EN(EN), .CLR(CLR), .LOAD(LOAD), .UP_DN(UP_DN),
        .D(d2), .Q(q2), .TC(tc2), .WRAP(wrap2), .ERR(err2)
    );

    bcd_counter_n #(.DIGITS(3), .SATURATE(0)) u_dut3 (
        .CLK(CLK), .RES(RES), .EN(EN), .CLR(CLR), .LOAD(LOAD), .UP_DN(UP_DN),
        .D(d3), .Q(q3), .TC(tc3), .WRAP(wrap3), .ERR(err3)
    );

    bcd_counter_n #(.DIGITS(2), .SATURATE(1)) u_duts (
        .CLK(CLK), .RES(RES), .EN(EN), .CLR(CLR), .LOAD(LOAD), .UP_DN(UP_DN),
        .D(ds), .Q(qs), .TC(tcs), .WRAP(wraps), .ERR(errs)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RES = 1'b0; EN = 1'b0; CLR = 1'b0; LOAD = 1'b0; UP_DN = 1'b1;
        d2 = 8'h00; d3 = 12'h000; ds = 8'h00;
        #3;
        checks++; if (q2 !== 8'h00) begin errors++; $display("FAIL reset_q2: got %h want 00", q2); end
        checks++; if (q3 !== 12'h000) begin errors++; $display("FAIL reset_q3: got %h want 000", q3); end
        checks++; if (wrap2 !== 1'b0 || err2 !== 1'b0) begin errors++; $display("FAIL reset_flags: wrap=%b err=%b want 0 0", wrap2, err2); end
        tick;
        RES = 1'b1;
    endtask

    task automatic test_count_up;
        logic [7:0] e;
        EN = 1'b1; UP_DN = 1'b1;
        #1;
        for (int n = 1; n <= 12; n++) begin
            checks++; if (tc2 !== 1'b0) begin errors++; $display("FAIL count_tc at %0d: got %b want 0", n, tc2); end
            tick;
            e = 8'((n / 10) * 16 + (n % 10));
            checks++; if (q2 !== e) begin errors++; $display("FAIL count_q step %0d: got %h want %h", n, q2, e); end
        end
        EN = 1'b0;
    endtask

    task automatic test_up_wrap;
        LOAD = 1'b1; d2 = 8'h98; d3 = 12'h000; ds = 8'h00;
        tick;
        LOAD = 1'b0;
        checks++; if (q2 !== 8'h98) begin errors++; $display("FAIL wrap_load: got %h want 98", q2); end
        EN = 1'b1; UP_DN = 1'b1;
        tick;
        checks++; if (q2 !== 8'h99 || tc2 !== 1'b1) begin errors++; $display("FAIL wrap_99: q=%h tc=%b want 99 1", q2, tc2); end
        tick;
        checks++; if (q2 !== 8'h00 || wrap2 !== 1'b1) begin errors++; $display("FAIL wrap_00: q=%h wrap=%b want 00 1", q2, wrap2); end
        tick;
        checks++; if (q2 !== 8'h01 || wrap2 !== 1'b0) begin errors++; $display("FAIL wrap_01: q=%h wrap=%b want 01 0", q2, wrap2); end
        EN = 1'b0;
    endtask

    task automatic test_down_borrow;
        LOAD = 1'b1; d3 = 12'h100;
        tick;
        LOAD = 1'b0; EN = 1'b1; UP_DN = 1'b0;
        tick;
        checks++; if (q3 !== 12'h099) begin errors++; $display("FAIL down_099: got %h want 099", q3); end
        tick;
        checks++; if (q3 !== 12'h098) begin errors++; $display("FAIL down_098: got %h want 098", q3); end
        // LOAD outranks EN in the same cycle.
        LOAD = 1'b1; d3 = 12'h000;
        tick;
        LOAD = 1'b0;
        checks++; if (q3 !== 12'h000 || tc3 !== 1'b1) begin errors++; $display("FAIL down_load0: q=%h tc=%b want 000 1", q3, tc3); end
        tick;
        checks++; if (q3 !== 12'h999 || wrap3 !== 1'b1) begin errors++; $display("FAIL down_wrap: q=%h wrap=%b want 999 1", q3, wrap3); end
        tick;
        checks++; if (q3 !== 12'h998 || wrap3 !== 1'b0) begin errors++; $display("FAIL down_after: q=%h wrap=%b want 998 0", q3, wrap3); end
        EN = 1'b0;
    endtask

    task automatic test_saturate;
        logic [7:0] exp_s [5];
        exp_s = '{8'h98, 8'h99, 8'h99, 8'h99, 8'h99};
        LOAD = 1'b1; ds = 8'h97;
        tick;
        LOAD = 1'b0; EN = 1'b1; UP_DN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++; if (qs !== exp_s[i]) begin errors++; $display("FAIL sat_q step %0d: got %h want %h", i, qs, exp_s[i]); end
            checks++; if (wraps !== 1'b0) begin errors++; $display("FAIL sat_wrap step %0d: got %b want 0", i, wraps); end
        end
        checks++; if (tcs !== 1'b1) begin errors++; $display("FAIL sat_tc: got %b want 1", tcs); end
        EN = 1'b0;
        LOAD = 1'b1; ds = 8'h00;
        tick;
        LOAD = 1'b0; EN = 1'b1; UP_DN = 1'b0;
        tick;
        tick;
        checks++; if (qs !== 8'h00 || wraps !== 1'b0 || tcs !== 1'b1) begin errors++; $display("FAIL sat_down: q=%h wrap=%b tc=%b want 00 0 1", qs, wraps, tcs); end
        EN = 1'b0;
    endtask

    task automatic test_load_err;
        LOAD = 1'b1; d2 = 8'h3C;
        tick;
        LOAD = 1'b0;
        checks++; if (q2 !== 8'h30 || err2 !== 1'b1) begin errors++; $display("FAIL lderr_3C: q=%h err=%b want 30 1", q2, err2); end
        EN = 1'b1; UP_DN = 1'b1;
        tick;
        checks++; if (q2 !== 8'h31 || err2 !== 1'b1) begin errors++; $display("FAIL lderr_count: q=%h err=%b want 31 1", q2, err2); end
        EN = 1'b0;
        tick;
        checks++; if (q2 !== 8'h31) begin errors++; $display("FAIL hold_en0: got %h want 31", q2); end
        CLR = 1'b1; LOAD = 1'b1; d2 = 8'h55;
        tick;
        CLR = 1'b0; LOAD = 1'b0;
        checks++; if (q2 !== 8'h00 || err2 !== 1'b0) begin errors++; $display("FAIL clr_load: q=%h err=%b want 00 0", q2, err2); end
        LOAD = 1'b1; d2 = 8'hF7;
        tick;
        LOAD = 1'b0;
        checks++; if (q2 !== 8'h07 || err2 !== 1'b1) begin errors++; $display("FAIL lderr_F7: q=%h err=%b want 07 1", q2, err2); end
    endtask

    task automatic test_async_reset;
        LOAD = 1'b1; d2 = 8'h5F;
        tick;
        LOAD = 1'b0; EN = 1'b1; UP_DN = 1'b1;
        for (int i = 0; i < 7; i++) tick;
        checks++; if (q2 !== 8'h57 || err2 !== 1'b1) begin errors++; $display("FAIL pre_rst: q=%h err=%b want 57 1", q2, err2); end
        #2;
        RES = 1'b0;
        #1;
        checks++; if (q2 !== 8'h00 || err2 !== 1'b0 || wrap2 !== 1'b0) begin errors++; $display("FAIL async_rst: q=%h err=%b wrap=%b want 00 0 0", q2, err2, wrap2); end
        tick;
        tick;
        tick;
        checks++; if (q2 !== 8'h00) begin errors++; $display("FAIL rst_hold: got %h want 00", q2); end
        RES = 1'b1;
        tick;
        checks++; if (q2 !== 8'h01) begin errors++; $display("FAIL rst_release: got %h want 01", q2); end
        EN = 1'b0;
    endtask

    initial begin
        test_reset;
        test_count_up;
        test_up_wrap;
        test_down_borrow;
        test_saturate;
        test_load_err;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
